gpu_control_unit: RTL and testbench
===================================

Name: gpu_control_unit

Overview:
- Parametrised successor to the console graphics processor's instruction control unit.
- Accepts one opcode per valid/ready handshake, decodes it, and sequences the register-bank and memory write strobes and datapath selectors.
- Multi-field polygon definition is a burst of writes that waits for the screen scan to finish.
- Memory writes have a configurable strobe length and a done-acknowledge wait with timeout.

Parameters:
- OPCODE_W, 4, opcode width.
- FIELD_W, 4, number of register fields; width of selectField.
- MEM_WR_CYCLES, 1, cycles memory_wr is held high (>=1).
- TIMEOUT, 16, max cycles in WAIT_DONE before error (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opCode is valid.
- opCode  in  OPCODE_W  instruction opcode.
- printtingScreen  in  1  high while the frame is being scanned out.
- done  in  1  memory write acknowledge.
- new_instruction  out  1  ready; high only in IDLE.
- memory_wr  out  1  memory write strobe.
- selectField  out  FIELD_W  one-hot field write select; 0 means whole word.
- register_wr  out  1  register bank write strobe.
- selectorDemuxRegister  out  1  0 = WBR path, 1 = DP path.
- selectorDemuxData  out  1  0 = sprite data, 1 = background data.
- selectorAddress  out  1  0 = sprite memory, 1 = background memory.
- busy  out  1  high in any state except IDLE.
- error  out  1  one-cycle pulse on illegal opcode or done timeout.

Behaviour:
- Outputs are Moore, decoded from the state register and the latched opcode only.
- While reset=0: state is IDLE, counters are 0, and the latched opcode is WBR. Outputs are new_instruction=1 and all others 0.
- States: IDLE, DECODE, WRITE_REG, WAIT_SCREEN, WRITE_FIELDS, WRITE_MEM, WAIT_DONE, ERR.
- IDLE: if instr_valid=1 at a rising edge, latch opCode and go to DECODE. Otherwise stay in IDLE.
- DECODE (1 cycle) routes the latched opcode:
  - WBR (0000) -> WRITE_REG.
  - WSM (0001) or WBM (0010) -> WRITE_MEM.
  - DP (0011) -> WAIT_SCREEN.
  - Any other value -> ERR.
- WRITE_REG (1 cycle): register_wr=1, selectField=0, selectorDemuxRegister=0, then IDLE. An accept at edge N gives new_instruction=1 again after edge N+2.
- WAIT_SCREEN: holds while printtingScreen=1; goes to WRITE_FIELDS on the edge where printtingScreen=0.
- WRITE_FIELDS lasts exactly FIELD_W cycles:
  - register_wr=1 and selectorDemuxRegister=1 throughout.
  - selectField=1<<k for k=0..FIELD_W-1.
  - Then IDLE.
  - printtingScreen rising mid-burst is ignored.
- WRITE_MEM lasts MEM_WR_CYCLES cycles:
  - memory_wr=1.
  - selectorAddress and selectorDemuxData are 0 for WSM, 1 for WBM; both are held through WAIT_DONE.
  - Then WAIT_DONE.
  - done is ignored in WRITE_MEM.
- WAIT_DONE:
  - done=1 -> IDLE.
  - Otherwise the counter increments; after TIMEOUT cycles without done -> ERR.
  - done=1 on the same edge that the timeout is reached wins, giving IDLE with no error.
- ERR (1 cycle): error=1, then IDLE. No strobes are asserted.
- Counters are sized $clog2 of max(FIELD_W, MEM_WR_CYCLES, TIMEOUT)+1 and are cleared on every state entry.
- Reset asserted mid-operation forces IDLE immediately (asynchronous). Any strobe in progress drops the same instant, and the burst is not resumed.
- instr_valid while busy is ignored. No queuing; the source must hold instr_valid until new_instruction=1.

Decomposition:
- Package gpu_ctrl_pkg holds:
  - the opcode localparams WBR, WSM, WBM, DP;
  - the state enum;
  - the selector encodings SEL_SPRITE=0, SEL_BACKGROUND=1.
- One sub-module, ctrl_cycle_counter: load-clear, increment, and terminal-count compare. It is shared by WRITE_FIELDS, WRITE_MEM and WAIT_DONE.

Test Plan:
- Reset and idle check: reset low for 2 cycles, then release with instr_valid=0 -> new_instruction=1, busy=0, every other output 0 for 5 cycles.
- WBR: opCode=0000 with a valid pulse -> register_wr=1 for exactly 1 cycle, two cycles after the accepting edge, with selectField=0000 and selectorDemuxRegister=0; new_instruction=1 at the next cycle.
- WSM with delayed ack: opCode=0001, MEM_WR_CYCLES=2, done raised 3 cycles into WAIT_DONE:
  - memory_wr is high for 2 cycles with selectorAddress=0 and selectorDemuxData=0;
  - busy stays high until done; error=0.
- WBM timeout: opCode=0010, done held at 0, TIMEOUT=16 -> selectors are 1; after 16 WAIT_DONE cycles error pulses for 1 cycle, then new_instruction=1.
- DP under scan: opCode=0011 with printtingScreen=1 for 5 cycles, then 0:
  - no register_wr during the wait;
  - then 4 cycles of register_wr=1 with selectField 0001, 0010, 0100, 1000 and selectorDemuxRegister=1.
- Illegal opcode and reset mid-burst:
  - opCode=1010 -> error=1 for 1 cycle and no strobes.
  - Separately, assert reset during the 2nd DP field cycle -> register_wr falls immediately; after release the unit is in IDLE.

Source files
------------

// File: rtl/gpu_ctrl_pkg.sv
// Shared opcodes, selector encodings and FSM state type for the GPU instruction control unit.
package gpu_ctrl_pkg;

  localparam logic [3:0] WBR = 4'b0000;
  localparam logic [3:0] WSM = 4'b0001;
  localparam logic [3:0] WBM = 4'b0010;
  localparam logic [3:0] DP  = 4'b0011;

  localparam logic SEL_SPRITE     = 1'b0;
  localparam logic SEL_BACKGROUND = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE_REG,
    WAIT_SCREEN,
    WRITE_FIELDS,
    WRITE_MEM,
    WAIT_DONE,
    ERR
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// Cycle counter shared by the timed FSM states: synchronous clear, increment and terminal compare.
module ctrl_cycle_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign at_last = (count == last);

endmodule

// File: rtl/gpu_control_unit.sv
// Instruction control unit: accepts one opcode per handshake and sequences register/memory strobes.
// Handshake: an opcode transfers on a rising edge where instr_valid=1 and new_instruction=1.
module gpu_control_unit
  import gpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 4,
  parameter int FIELD_W       = 4,
  parameter int MEM_WR_CYCLES = 1,
  parameter int TIMEOUT       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                printtingScreen,
  input  logic                done,
  output logic                new_instruction,
  output logic                memory_wr,
  output logic [FIELD_W-1:0]  selectField,
  output logic                register_wr,
  output logic                selectorDemuxRegister,
  output logic                selectorDemuxData,
  output logic                selectorAddress,
  output logic                busy,
  output logic                error,
  output state_t              dbg_state
);

  localparam int CNT_MAX = max3(FIELD_W, MEM_WR_CYCLES, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  state_t              state_next;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_last;
  logic                cnt_at_last;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                sel_bg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OPCODE_W'(WBR);
    end else begin
      state <= state_next;
      if (state == IDLE && instr_valid) begin
        op_q <= opCode;
      end
    end
  end

  // Every state change restarts the count, so each timed state starts from zero.
  assign cnt_clear = (state_next != state);
  assign cnt_inc   = (state == WRITE_FIELDS) || (state == WRITE_MEM) || (state == WAIT_DONE);
  assign sel_bg    = (op_q == OPCODE_W'(WBM)) ? SEL_BACKGROUND : SEL_SPRITE;
  assign dbg_state = state;

  ctrl_cycle_counter #(
    .W(CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .last   (cnt_last),
    .count  (cnt),
    .at_last(cnt_at_last)
  );

  always_comb begin
    state_next            = state;
    cnt_last              = '0;
    new_instruction       = 1'b0;
    busy                  = 1'b1;
    error                 = 1'b0;
    memory_wr             = 1'b0;
    register_wr           = 1'b0;
    selectField           = '0;
    selectorDemuxRegister = 1'b0;
    selectorDemuxData     = SEL_SPRITE;
    selectorAddress       = SEL_SPRITE;

    case (state)
      IDLE: begin
        new_instruction = 1'b1;
        busy            = 1'b0;
        if (instr_valid) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (op_q == OPCODE_W'(WBR)) begin
          state_next = WRITE_REG;
        end else if (op_q == OPCODE_W'(WSM) || op_q == OPCODE_W'(WBM)) begin
          state_next = WRITE_MEM;
        end else if (op_q == OPCODE_W'(DP)) begin
          state_next = WAIT_SCREEN;
        end else begin
          state_next = ERR;
        end
      end
      WRITE_REG: begin
        register_wr = 1'b1;
        state_next  = IDLE;
      end
      WAIT_SCREEN: begin
        if (!printtingScreen) begin
          state_next = WRITE_FIELDS;
        end
      end
      WRITE_FIELDS: begin
        register_wr           = 1'b1;
        selectorDemuxRegister = 1'b1;
        cnt_last              = CNT_W'(FIELD_W - 1);
        for (int k = 0; k < FIELD_W; k++) begin
          selectField[k] = (cnt == CNT_W'(k));
        end
        if (cnt_at_last) begin
          state_next = IDLE;
        end
      end
      WRITE_MEM: begin
        memory_wr         = 1'b1;
        selectorAddress   = sel_bg;
        selectorDemuxData = sel_bg;
        cnt_last          = CNT_W'(MEM_WR_CYCLES - 1);
        if (cnt_at_last) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        selectorAddress   = sel_bg;
        selectorDemuxData = sel_bg;
        cnt_last          = CNT_W'(TIMEOUT - 1);
        // An acknowledge on the timeout edge takes priority over the error.
        if (done) begin
          state_next = IDLE;
        end else if (cnt_at_last) begin
          state_next = ERR;
        end
      end
      ERR: begin
        error      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gpu_control_unit.sv
// Randomized scoreboard bench for gpu_control_unit: per-cycle expected output words are queued
// by the driver from a transaction-level model and checked by an independent monitor.
module tb_gpu_control_unit;

  localparam int OPCODE_W      = 4;
  localparam int FIELD_W       = 4;
  localparam int MEM_WR_CYCLES = 2;
  localparam int TIMEOUT       = 16;
  localparam int W             = 8 + FIELD_W;

  logic                clk;
  logic                reset;
  logic                instr_valid;
  logic [OPCODE_W-1:0] opCode;
  logic                printtingScreen;
  logic                done;
  logic                new_instruction;
  logic                memory_wr;
  logic [FIELD_W-1:0]  selectField;
  logic                register_wr;
  logic                selectorDemuxRegister;
  logic                selectorDemuxData;
  logic                selectorAddress;
  logic                busy;
  logic                error;
  gpu_ctrl_pkg::state_t dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  int           checks = 0;
  int           errors = 0;

  gpu_control_unit #(
    .OPCODE_W     (OPCODE_W),
    .FIELD_W      (FIELD_W),
    .MEM_WR_CYCLES(MEM_WR_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_valid          (instr_valid),
    .opCode               (opCode),
    .printtingScreen      (printtingScreen),
    .done                 (done),
    .new_instruction      (new_instruction),
    .memory_wr            (memory_wr),
    .selectField          (selectField),
    .register_wr          (register_wr),
    .selectorDemuxRegister(selectorDemuxRegister),
    .selectorDemuxData    (selectorDemuxData),
    .selectorAddress      (selectorAddress),
    .busy                 (busy),
    .error                (error),
    .dbg_state            (dbg_state)
  );

  assign act = {new_instruction, busy, error, memory_wr, register_wr, selectField,
                selectorDemuxRegister, selectorDemuxData, selectorAddress};

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic ni, input logic bsy, input logic err,
                                      input logic mwr, input logic rwr,
                                      input logic [FIELD_W-1:0] fld, input logic dreg,
                                      input logic ddat, input logic saddr);
    return {ni, bsy, err, mwr, rwr, fld, dreg, ddat, saddr};
  endfunction

  function automatic logic [W-1:0] idle_word();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d queued words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reference model: one busy word per cycle from accept to return to IDLE.
  // s = extra scan cycles seen in WAIT_SCREEN; d = WAIT_DONE cycle carrying done (> TIMEOUT: never).
  task automatic push_trace(input logic [3:0] op, input int s, input int d, output int len);
    logic               bg;
    logic [FIELD_W-1:0] fld;
    int                 waits;
    len = 0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    len++;
    case (op)
      4'h0: begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0));
        len++;
      end
      4'h1, 4'h2: begin
        bg = (op == 4'h2);
        repeat (MEM_WR_CYCLES) begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, bg, bg));
          len++;
        end
        waits = (d <= TIMEOUT) ? d : TIMEOUT;
        repeat (waits) begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, bg, bg));
          len++;
        end
        if (d > TIMEOUT) begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
          len++;
        end
      end
      4'h3: begin
        repeat (s + 1) begin
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
          len++;
        end
        for (int k = 0; k < FIELD_W; k++) begin
          fld = '0;
          fld[k] = 1'b1;
          exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, fld, 1'b1, 1'b0, 1'b0));
          len++;
        end
      end
      default: begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
        len++;
      end
    endcase
  endtask

  // Driver: waits for ready, then shapes printtingScreen/done per cycle; other cycles get noise.
  task automatic wait_ready(output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!new_instruction && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: got new_instruction=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic issue(input logic [3:0] op, input int s, input int d);
    int len;
    bit ok;
    bit mem;
    bit dpop;
    mem  = (op == 4'h1) || (op == 4'h2);
    dpop = (op == 4'h3);
    wait_ready(ok);
    if (!ok) return;
    instr_valid     = 1'b1;
    opCode          = op;
    printtingScreen = dpop ? 1'b1 : 1'($urandom_range(0, 1));
    done            = 1'($urandom_range(0, 1));
    @(posedge clk);
    push_trace(op, s, d, len);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      instr_valid = 1'($urandom_range(0, 1));
      opCode      = 4'($urandom);
      if (dpop) begin
        if (c <= s + 1)      printtingScreen = 1'b1;
        else if (c == s + 2) printtingScreen = 1'b0;
        else                 printtingScreen = 1'($urandom_range(0, 1));
      end else begin
        printtingScreen = 1'($urandom_range(0, 1));
      end
      if (mem && c > 1 + MEM_WR_CYCLES) done = ((c - 1 - MEM_WR_CYCLES) == d);
      else                              done = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    check_drained("trace_drained");
    instr_valid     = 1'b0;
    done            = 1'b0;
    printtingScreen = 1'b0;
  endtask

  task automatic reset_mid_burst();
    bit ok;
    logic [FIELD_W-1:0] f0;
    wait_ready(ok);
    if (!ok) return;
    instr_valid     = 1'b1;
    opCode          = 4'h3;
    printtingScreen = 1'b0;
    done            = 1'b0;
    @(posedge clk);
    f0 = '0;
    f0[0] = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, f0, 1'b1, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
    end
    #1;
    check("field1_strobe", W'({register_wr, selectField}), W'({1'b1, 4'b0010}));
    #1;
    reset = 1'b0;
    #1;
    check("reset_drop", act, idle_word());
    check("reset_state", W'(dbg_state), W'(gpu_ctrl_pkg::IDLE));
    check_drained("reset_drained");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: one comparison per cycle, queued word while a transaction is pending, else idle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("trace", act, e);
    end else begin
      check("idle", act, idle_word());
    end
  end

  // Stimulus sequence and final report
  initial begin
    logic [3:0] op;
    int         r;
    reset           = 1'b0;
    instr_valid     = 1'b0;
    opCode          = '0;
    printtingScreen = 1'b0;
    done            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    issue(4'h0, 0, 0);
    issue(4'h1, 0, 3);
    issue(4'h2, 0, TIMEOUT + 1);
    issue(4'h2, 0, TIMEOUT);
    issue(4'h1, 0, 1);
    issue(4'h3, 5, 0);
    issue(4'h3, 0, 0);
    issue(4'b1010, 0, 0);
    reset_mid_burst();
    issue(4'h0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      op = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
      issue(op, $urandom_range(0, 6), $urandom_range(1, TIMEOUT + 2));
    end

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
